cla_add_scheduler: RTL

//  Shares one 16-bit carry-lookahead adder instance among NREQ requesters in the multi-cycle CPU.

---
 rtl/cla_add_scheduler.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/cla_add_scheduler.sv
// ---------------------------------------------------------------------------
// cla_add_scheduler
//
// Shares one external 16-bit carry-lookahead adder among NREQ requesters.
// A WIDTH-bit add or subtract is performed as S = WIDTH/16 passes through
// the adder, low slice first, with the carry out of each pass fed into the
// next. Requesters are served round-robin. Requests and responses use
// valid/ready handshakes, and the result is held in registers.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   req_valid   per-requester request valid
//   req_ready   per-requester accept strobe (one-hot or zero, IDLE only)
//   req_a       operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b       operand B, same packing
//   req_sub     per-requester op select: 1 = A-B, 0 = A+B
//   resp_valid  result available
//   resp_ready  consumer accepts result
//   resp_id     index of the requester that owns the result
//   resp_sum    WIDTH-bit result
//   resp_cout   carry out of the MSB (for subtract, 1 = no borrow)
//   resp_ovf    signed overflow
//   cla_a       adder operand A slice
//   cla_b       adder operand B slice (already inverted for subtract)
//   cla_cin     adder carry in
//   cla_sum     adder sum (combinational return)
//   cla_cout    adder carry out (combinational return)
// ---------------------------------------------------------------------------
module cla_add_scheduler #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  input  logic [NREQ-1:0]          req_sub,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [WIDTH-1:0]         resp_sum,
  output logic                     resp_cout,
  output logic                     resp_ovf,
  output logic [15:0]              cla_a,
  output logic [15:0]              cla_b,
  output logic                     cla_cin,
  input  logic [15:0]              cla_sum,
  input  logic                     cla_cout
);

  localparam int S   = WIDTH / 16;
  localparam int KW  = (S > 1) ? $clog2(S) : 1;
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r;
  logic [S-1:0][15:0]     a_r;       // latched operand A, one entry per slice
  logic [S-1:0][15:0]     b_r;       // latched operand B, inverted for subtract
  logic [S-1:0][15:0]     sum_r;     // result, filled one slice per CALC cycle
  logic [KW-1:0]          k_r;       // slice currently in the adder
  logic [IDW-1:0]         ptr_r;     // last requester granted

  logic                   grant_found_s;
  logic [IDW-1:0]         grant_id_s;
  logic [S-1:0][15:0]     sel_a_s;
  logic [S-1:0][15:0]     sel_b_s;
  logic                   sel_sub_s;
  logic                   last_s;
  logic [KW-1:0]          nxt_k_s;

  assign resp_sum = sum_r;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    int idx;
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    idx           = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr_r) + i) % NREQ;
      if (!grant_found_s && req_valid[idx]) begin
        grant_found_s = 1'b1;
        grant_id_s    = IDW'(idx);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Ready goes only to the winner, only in IDLE, and never while reset is applied.
  always_comb begin
    req_ready = '0;
    if (reset_n && (state_r == IDLE) && grant_found_s) begin
      req_ready[grant_id_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Operand mux for the winning requester; B is pre-inverted for subtract.
  always_comb begin
    sel_sub_s = req_sub[grant_id_s];
    sel_a_s   = req_a[int'(grant_id_s) * WIDTH +: WIDTH];
    sel_b_s   = req_b[int'(grant_id_s) * WIDTH +: WIDTH] ^ {WIDTH{sel_sub_s}};
  end

  // Slice sequencing helpers.
  always_comb begin
    last_s = (k_r == KW'(S - 1));
    if (last_s) begin
      nxt_k_s = '0;
    end else begin
      nxt_k_s = k_r + KW'(1);
    end
  end

  // Main FSM. The adder inputs are registered: they are loaded with the slice
  // to be added during the next cycle, so they are valid for the whole CALC
  // cycle in which the returning sum is captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      sum_r      <= '0;
      k_r        <= '0;
      ptr_r      <= IDW'(NREQ - 1);
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_cout  <= 1'b0;
      resp_ovf   <= 1'b0;
      cla_a      <= 16'h0000;
      cla_b      <= 16'h0000;
      cla_cin    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_found_s) begin
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            resp_id <= grant_id_s;
            ptr_r   <= grant_id_s;
            k_r     <= '0;
            cla_a   <= sel_a_s[0];
            cla_b   <= sel_b_s[0];
            cla_cin <= sel_sub_s;   // +1 completes the two's complement of B
            state_r <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end

        CALC: begin
          sum_r[k_r] <= cla_sum;
          k_r        <= nxt_k_s;
          if (last_s) begin
            // Overflow: operand signs agree and the result sign differs.
            resp_valid <= 1'b1;
            resp_cout  <= cla_cout;
            resp_ovf   <= (a_r[S-1][15] == b_r[S-1][15]) &&
                          (cla_sum[15] != a_r[S-1][15]);
            cla_a      <= 16'h0000;
            cla_b      <= 16'h0000;
            cla_cin    <= 1'b0;
            state_r    <= DONE;
          end else begin
            cla_a      <= a_r[nxt_k_s];
            cla_b      <= b_r[nxt_k_s];
            cla_cin    <= cla_cout;
            state_r    <= CALC;
          end
        end

        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_r    <= IDLE;
          end else begin
            state_r    <= DONE;
          end
        end

        default: begin
          resp_valid <= 1'b0;
          cla_a      <= 16'h0000;
          cla_b      <= 16'h0000;
          cla_cin    <= 1'b0;
          k_r        <= '0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule
